multicore_mem_arbiter: RTL and testbench

- Shared data memory with an N-way round-robin arbiter for the multicore processor.
- Generalises the fixed two-core arrangement (result/result2, carry/carry2) to NUM_CORES requesters.
- Adds a configurable read-latency pipeline.
- Sits between the core pipelines' MEM stages and a single on-chip word array, inside multicore_cpu.

---
 rtl/multicore_pkg.sv | 36 +++
 rtl/multicore_mem_arbiter_rr_arbiter.sv | 89 ++++++++
 rtl/multicore_mem_arbiter.sv | 105 ++++++++++
 tb/tb_multicore_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types and helpers for the multicore memory arbiter.
// Holds the arbiter state encoding and the round-robin search function.
package multicore_pkg;

  localparam int MAX_CORES      = 8;
  localparam int MAX_RD_LATENCY = 4;
  localparam int CORE_IDX_W     = $clog2(MAX_CORES);

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic                  found;
    logic [CORE_IDX_W-1:0] idx;
  } rr_pick_t;

  // Search req starting one past 'last', wrapping within num_cores.
  function automatic rr_pick_t rr_pick(input logic [MAX_CORES-1:0]  req,
                                       input logic [CORE_IDX_W-1:0] last,
                                       input int                    num_cores);
    rr_pick_t result;
    int pos;
    result = '0;
    for (int k = 1; k <= MAX_CORES; k++) begin
      pos = (int'(last) + k) % num_cores;
      if (k <= num_cores && !result.found && req[pos]) begin
        result.found = 1'b1;
        result.idx   = pos[CORE_IDX_W-1:0];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/multicore_mem_arbiter_rr_arbiter.sv
// N-way round-robin arbiter with its last-grant pointer.
// ARB_LOCK_EN adds a lock input and an IDLE/LOCKED state exposed on 'state'.
module rr_arbiter
  import multicore_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic [NUM_CORES-1:0] lock,
  output arb_state_e           state,
`endif
  output logic [NUM_CORES-1:0] gnt,
  output logic                 grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0]      last_gnt;
  logic [NUM_CORES-1:0]  req_eff;
  logic [MAX_CORES-1:0]  req_ext;
  logic [CORE_IDX_W-1:0] last_ext;
  rr_pick_t              pick;

`ifdef ARB_LOCK_EN
  arb_state_e       state_next;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_next;

  // While locked, only the owner may compete.
  always_comb begin
    req_eff = req;
    if (state == ARB_LOCKED) begin
      req_eff        = '0;
      req_eff[owner] = req[owner];
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      ARB_IDLE: begin
        if (grant && lock[grant_idx]) begin
          state_next = ARB_LOCKED;
          owner_next = grant_idx;
        end
      end
      ARB_LOCKED: begin
        if (!req[owner] || !lock[owner]) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end
`else
  assign req_eff = req;
`endif

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_CORES-1:0]   = req_eff;
    last_ext                 = '0;
    last_ext[IDX_W-1:0]      = last_gnt;
    pick                     = rr_pick(req_ext, last_ext, NUM_CORES);
    grant                    = pick.found;
    grant_idx                = pick.idx[IDX_W-1:0];
    gnt                      = '0;
    if (pick.found) gnt[grant_idx] = 1'b1;
  end

  // In the locked state the winner is always the owner, so tracking every grant is equivalent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_gnt <= IDX_W'(NUM_CORES - 1);
    else if (grant) last_gnt <= grant_idx;
  end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Shared data memory behind an N-way round-robin arbiter with a read-latency pipeline.
// Define ARB_LOCK_EN to add the per-core lock input for read-modify-write sequences.
module multicore_mem_arbiter
  import multicore_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int DATA_SIZE  = 32,
  parameter int MEM_SIZE   = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                           sys_clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           req,
  input  logic [NUM_CORES-1:0]           we,
  input  logic [NUM_CORES*MEM_SIZE-1:0]  addr,
  input  logic [NUM_CORES*DATA_SIZE-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]           lock,
`endif
  output logic [NUM_CORES-1:0]           gnt,
  output logic [NUM_CORES-1:0]           rvalid,
  output logic [DATA_SIZE-1:0]           rdata,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int DEPTH = 2 ** MEM_SIZE;

  logic                 grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [MEM_SIZE-1:0]  sel_addr;
  logic [DATA_SIZE-1:0] sel_wdata;
  logic                 sel_we;
  logic                 rd_fire;

  logic [DATA_SIZE-1:0] mem        [DEPTH];
  logic                 pipe_valid [RD_LATENCY];
  logic [IDX_W-1:0]     pipe_idx   [RD_LATENCY];
  logic [DATA_SIZE-1:0] pipe_data  [RD_LATENCY];

`ifdef ARB_LOCK_EN
  arb_state_e arb_state;
`endif

  rr_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_arb (
    .clk       (sys_clk),
    .rst       (reset),
    .req       (req),
`ifdef ARB_LOCK_EN
    .lock      (lock),
    .state     (arb_state),
`endif
    .gnt       (gnt),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_addr  = addr[grant_idx*MEM_SIZE +: MEM_SIZE];
  assign sel_wdata = wdata[grant_idx*DATA_SIZE +: DATA_SIZE];
  assign sel_we    = we[grant_idx];
  assign rd_fire   = grant && !sel_we;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (grant && sel_we) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // Data/index only advance behind a valid bit, so the last stage keeps the
  // most recently returned word and rdata holds between strobes.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_idx[s]   <= '0;
        pipe_data[s]  <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_fire;
      if (rd_fire) begin
        pipe_idx[0]  <= grant_idx;
        pipe_data[0] <= mem[sel_addr];
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        if (pipe_valid[s-1]) begin
          pipe_idx[s]  <= pipe_idx[s-1];
          pipe_data[s] <= pipe_data[s-1];
        end
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (pipe_valid[RD_LATENCY-1]) rvalid[pipe_idx[RD_LATENCY-1]] = 1'b1;
    busy = 1'b0;
    for (int s = 0; s < RD_LATENCY; s++) busy = busy | pipe_valid[s];
  end

  assign rdata = pipe_data[RD_LATENCY-1];

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Directed and randomized bench for multicore_mem_arbiter against a cycle-level reference model.
module tb_multicore_mem_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int LAT = 3;

  logic            sys_clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
`ifdef ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;

  multicore_mem_arbiter #(.NUM_CORES(N), .DATA_SIZE(DW), .MEM_SIZE(AW), .RD_LATENCY(LAT)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: memory contents, pointer, in-flight reads with return cycle.
  typedef struct {
    int          ret;
    int          core;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mdl_mem [2**AW];
  int            mdl_last;
  rd_t           inflight[$];
  logic [DW-1:0] exp_rdata;
  bit            lk_on;
  int            lk_owner;
  int            cyc;
  int            last_w;
  logic [N-1:0]  seen_gnt, seen_rvalid;
  logic [DW-1:0] seen_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    int pos;
    if (lk_on) return req[lk_owner] ? lk_owner : -1;
    for (int k = 1; k <= N; k++) begin
      pos = (mdl_last + k) % N;
      if (req[pos]) return pos;
    end
    return -1;
  endfunction

  task automatic model_reset();
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    mdl_last  = N - 1;
    inflight.delete();
    exp_rdata = '0;
    lk_on     = 1'b0;
    lk_owner  = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_gnt, exp_rv;
    logic exp_busy;
    logic [AW-1:0] a;
    @(negedge sys_clk);
    w = model_winner();
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    exp_rv = '0;
    exp_busy = 1'b0;
    foreach (inflight[i]) begin
      if (inflight[i].ret == cyc) begin
        exp_rv[inflight[i].core] = 1'b1;
        exp_rdata = inflight[i].data;
      end
      if (inflight[i].ret >= cyc) exp_busy = 1'b1;
    end
    seen_gnt = gnt;
    seen_rvalid = rvalid;
    seen_rdata = rdata;
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("rvalid", 64'(rvalid), 64'(exp_rv));
    check("rdata", 64'(rdata), 64'(exp_rdata));
    check("busy", 64'(busy), 64'(exp_busy));
    @(posedge sys_clk);
    if (w >= 0) begin
      a = addr[w*AW +: AW];
      if (we[w]) mdl_mem[a] = wdata[w*DW +: DW];
      else inflight.push_back('{ret: cyc + LAT, core: w, data: mdl_mem[a]});
      mdl_last = w;
    end
`ifdef ARB_LOCK_EN
    if (lk_on) begin
      if (!req[lk_owner] || !lock[lk_owner]) lk_on = 1'b0;
    end else if (w >= 0 && lock[w]) begin
      lk_on = 1'b1;
      lk_owner = w;
    end
`endif
    while (inflight.size() > 0 && inflight[0].ret <= cyc) void'(inflight.pop_front());
    last_w = w;
    cyc++;
    #1;
  endtask

  task automatic set_core(input int c, input logic r, input logic w, input int a, input logic [DW-1:0] d);
    req[c] = r;
    we[c] = w;
    addr[c*AW +: AW] = AW'(a);
    wdata[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req = '0;
    we = '0;
    reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_gnt", 64'(gnt), 64'(0));
    model_reset();
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    cyc = 0;
    last_w = -1;
    model_reset();
    #1;
    do_reset();

    // Single write then read by core 2.
    set_core(2, 1'b1, 1'b1, 'h10, 32'hDEADBEEF);
    cycle();
    check("t1_wr_gnt", 64'(seen_gnt), 64'(4'b0100));
    set_core(2, 1'b1, 1'b0, 'h10, '0);
    cycle();
    check("t1_rd_gnt", 64'(seen_gnt), 64'(4'b0100));
    req = '0;
    repeat (LAT) cycle();
    check("t1_rvalid", 64'(seen_rvalid), 64'(4'b0100));
    check("t1_rdata", 64'(seen_rdata), 64'(32'hDEADBEEF));

    // All cores read continuously: strict rotation from core 0.
    do_reset();
    for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b0, c + 1, '0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t2_order", 64'(seen_gnt), 64'(1 << (i % N)));
    end
    req = '0;
    repeat (LAT + 1) cycle();

    // Read data is captured at grant; a later write does not disturb it.
    set_core(0, 1'b1, 1'b1, 'h05, 32'h11);
    cycle();
    set_core(0, 1'b1, 1'b0, 'h05, '0);
    cycle();
    req = '0;
    set_core(1, 1'b1, 1'b1, 'h05, 32'h22);
    cycle();
    req = '0;
    repeat (LAT - 1) cycle();
    check("t3_old", 64'(seen_rdata), 64'(32'h11));
    set_core(0, 1'b1, 1'b0, 'h05, '0);
    cycle();
    req = '0;
    repeat (LAT) cycle();
    check("t3_new", 64'(seen_rdata), 64'(32'h22));

    // After core 3 wins, cores 0 and 3 together: 0 then 3.
    set_core(3, 1'b1, 1'b0, 'h07, '0);
    cycle();
    req = '0;
    cycle();
    set_core(3, 1'b1, 1'b0, 'h07, '0);
    set_core(0, 1'b1, 1'b0, 'h08, '0);
    cycle();
    check("t4_first", 64'(seen_gnt), 64'(4'b0001));
    req[0] = 1'b0;
    cycle();
    check("t4_second", 64'(seen_gnt), 64'(4'b1000));
    req = '0;
    repeat (LAT) cycle();

    // Reset with a read in flight: nothing returns, memory is cleared.
    set_core(1, 1'b1, 1'b1, 'h30, 32'hA5A5_1234);
    cycle();
    set_core(1, 1'b1, 1'b0, 'h30, '0);
    cycle();
    req = '0;
    cycle();
    do_reset();
    repeat (LAT + 1) cycle();
    set_core(1, 1'b1, 1'b0, 'h30, '0);
    cycle();
    req = '0;
    repeat (LAT) cycle();
    check("t5_rvalid", 64'(seen_rvalid), 64'(4'b0010));
    check("t5_rdata", 64'(seen_rdata), 64'(0));

`ifdef ARB_LOCK_EN
    // Locked owner excludes others until it drops lock.
    do_reset();
    set_core(1, 1'b1, 1'b0, 'h02, '0);
    lock[1] = 1'b1;
    cycle();
    check("t6_lock_gnt", 64'(seen_gnt), 64'(4'b0010));
    set_core(0, 1'b1, 1'b0, 'h03, '0);
    set_core(2, 1'b1, 1'b0, 'h04, '0);
    repeat (2) begin
      cycle();
      check("t6_held", 64'(seen_gnt), 64'(4'b0010));
    end
    lock[1] = 1'b0;
    cycle();
    check("t6_release", 64'(seen_gnt), 64'(4'b0010));
    req[1] = 1'b0;
    cycle();
    check("t6_next2", 64'(seen_gnt), 64'(4'b0100));
    req[2] = 1'b0;
    cycle();
    check("t6_next0", 64'(seen_gnt), 64'(4'b0001));
    req = '0;
    lock = '0;
    repeat (LAT) cycle();
`endif

    // Random traffic: each core holds its request until granted.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!req[c] && $urandom_range(0, 2) == 0)
          set_core(c, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
      end
      cycle();
      if (last_w >= 0) req[last_w] = 1'b0;
    end
    req = '0;
    repeat (LAT + 1) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
